trace_request_dispatcher: RTL
=============================

Name: trace_request_dispatcher

Overview:
- Sits directly downstream of the trace repository and consumes active-set entries (trace index plus data memory address).
- Issues one cache request per entry and tracks each in-flight request in a small tracker table, with one cache_tracker_t-style record per slot.
- Retires each entry back to the repository, tagged with its trace index, once the cache has processed it.
- Provides the per-request lifecycle MAKE_REQUEST -> WAIT_FOR_PROCESSING -> REQUEST_RETIRED.

Parameters:
- TRACE_ENTRIES, 8192, depth of the trace repository; index width is $clog2(TRACE_ENTRIES).
- DATA_ADDR_WIDTH, 32, data memory address width.
- TRACKER_SLOTS, 4, number of concurrent in-flight requests (power of two, at least 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- in_valid  in  1  active-set entry offered.
- in_ready  out  1  entry accepted when in_valid && in_ready.
- in_index  in  $clog2(TRACE_ENTRIES)  trace index of the offered entry.
- in_addr  in  DATA_ADDR_WIDTH  memory address of the offered entry.
- req_valid  out  1  cache request valid.
- req_ready  in  1  cache accepts the request.
- req_addr  out  DATA_ADDR_WIDTH  request address.
- req_slot  out  $clog2(TRACKER_SLOTS)  tag returned with the response.
- rsp_valid  in  1  cache finished processing a request.
- rsp_slot  in  $clog2(TRACKER_SLOTS)  tag of the finished request.
- retire_valid  out  1  single-cycle retirement pulse.
- retire_index  out  $clog2(TRACE_ENTRIES)  trace index being retired.
- retire_addr  out  DATA_ADDR_WIDTH  address being retired.
- occupancy  out  $clog2(TRACKER_SLOTS)+1  number of occupied slots.
- tag_error  out  1  sticky flag: response received for a slot not in WAIT_FOR_PROCESSING.

Behaviour:
- Reset:
  - Single clock clk; asynchronous, active-low reset rst_n.
  - While rst_n is low, every slot is unoccupied and every output is 0: in_ready, req_valid, req_addr, req_slot, retire_valid, retire_index, retire_addr, occupancy, tag_error.
  - in_ready first rises in the cycle after rst_n deasserts.
  - Reset asserted mid-operation drops all in-flight slots with no retirement; late responses arriving after reset set tag_error.
- Slot state:
  - Each slot holds occupied, mem_addr, trace_index and a mem_action state.
  - A free slot is unoccupied; its state is don't-care.
- Accept path:
  - in_ready = (a free slot exists) && (no occupied slot has mem_addr == in_addr).
  - in_ready is computed only from registered state and in_addr; it is not combinationally dependent on in_valid.
  - The address-hazard check stalls duplicates until the earlier entry retires.
  - On acceptance the entry is written to the lowest-numbered free slot in state MAKE_REQUEST, and occupancy increments at that edge.
  - A slot freed by retirement in cycle N is allocatable from cycle N+1, not in the same cycle.
- Request path:
  - req_valid is asserted whenever any slot is in MAKE_REQUEST. It is a registered output, first asserted the cycle after acceptance.
  - The chosen slot is the lowest-numbered slot in MAKE_REQUEST.
  - req_addr and req_slot stay stable while req_valid && !req_ready.
  - On req_valid && req_ready the slot moves to WAIT_FOR_PROCESSING.
  - At most one request is issued per cycle.
- Response path:
  - rsp_valid with rsp_slot in WAIT_FOR_PROCESSING moves that slot to REQUEST_RETIRED at the next edge.
  - rsp_valid for a slot in any other state, or unoccupied, is ignored and sets tag_error; it is cleared only by reset.
  - A response in the same cycle as that slot's handshake is impossible by protocol; a response then is treated as the error case.
- Retire path:
  - Each cycle, the lowest-numbered slot in REQUEST_RETIRED is retired.
  - retire_valid pulses for one cycle, registered, with that slot's trace_index and mem_addr.
  - The slot becomes unoccupied at the same edge, and occupancy decrements.
  - Retirement has no backpressure.
- Simultaneous events:
  - Acceptance, issue, response and retirement on distinct slots can all occur in one cycle.
  - occupancy reflects the net change: +1 if accepted, -1 if retired.
- Arithmetic: occupancy never exceeds TRACKER_SLOTS; when full, in_ready = 0.

Decomposition:
- Add to the trace repository datatypes package:
  - tracker_slot_t: occupied, mem_addr, processing state (the mem_action encoding as a named typedef), trace_index.
  - a slot-index width localparam.
- The existing active_set_entry is the input record.
- One natural sub-module, lowest_set_picker: a parameterised priority encoder returning the lowest set bit index plus an any-set flag. It is instantiated three times: free-slot allocation, request selection and retire selection.

Test Plan:
- Single entry: index 0x005, addr 0x0000_1000, req_ready=1, response on slot 0 three cycles later -> req_valid one cycle after acceptance with req_addr 0x1000, req_slot 0; retire_valid pulses once with index 0x005; occupancy returns 0→1→0.
- Fill with 4 distinct addresses and hold req_ready=0 -> in_ready=0 with occupancy=4. Raise req_ready -> requests issue in slot order 0,1,2,3, one per cycle.
- Duplicate address 0x2000 offered while 0x2000 is in flight -> in_ready=0 until the first entry retires, then accepted, and a second request for 0x2000 is issued.
- Out-of-order responses to slots 2, 0, 1 -> retirements occur in response order, each carrying the matching trace index and address.
- Response to an unoccupied slot 3 -> tag_error=1 and stays 1, with no retire pulse. Then assert rst_n=0 mid-flight -> all outputs 0 immediately, occupancy 0, and tag_error cleared.

Source files
------------

// File: rtl/trace_request_dispatcher_pkg.sv
// Shared datatypes for the trace repository and its request dispatcher.
// Slot storage widths come from the defaults here; dispatcher parameters must match them.
package trace_request_dispatcher_pkg;

    localparam int TRD_TRACE_ENTRIES  = 8192;
    localparam int TRD_DATA_ADDR_W    = 32;
    localparam int TRD_TRACKER_SLOTS  = 4;
    localparam int TRD_INDEX_W        = $clog2(TRD_TRACE_ENTRIES);
    localparam int TRD_SLOT_W         = $clog2(TRD_TRACKER_SLOTS);

    typedef enum logic [1:0] {
        MAKE_REQUEST        = 2'd0,
        WAIT_FOR_PROCESSING = 2'd1,
        REQUEST_RETIRED     = 2'd2
    } mem_action_e;

    typedef struct packed {
        logic [TRD_INDEX_W-1:0]     trace_index;
        logic [TRD_DATA_ADDR_W-1:0] mem_addr;
    } active_set_entry_t;

    typedef struct packed {
        logic                       occupied;
        logic [TRD_DATA_ADDR_W-1:0] mem_addr;
        mem_action_e                action;
        logic [TRD_INDEX_W-1:0]     trace_index;
    } tracker_slot_t;

endpackage

// File: rtl/trace_request_dispatcher_picker.sv
// Priority encoder: index of the lowest set bit plus an any-set flag.
// Purely combinational, no backpressure.
module lowest_set_picker #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        any = |req_vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_vec[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/trace_request_dispatcher.sv
// Tracks active-set entries through cache request, wait and retirement; req/retire registered, 1 cycle after the causing edge.
// Backpressure: in_ready drops when full or on an in-flight address match; req held stable while !req_ready; retire never stalls.
module trace_request_dispatcher
    import trace_request_dispatcher_pkg::*;
#(
    parameter int TRACE_ENTRIES   = TRD_TRACE_ENTRIES,
    parameter int DATA_ADDR_WIDTH = TRD_DATA_ADDR_W,
    parameter int TRACKER_SLOTS   = TRD_TRACKER_SLOTS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [$clog2(TRACE_ENTRIES)-1:0]  in_index,
    input  logic [DATA_ADDR_WIDTH-1:0]        in_addr,
    output logic                              req_valid,
    input  logic                              req_ready,
    output logic [DATA_ADDR_WIDTH-1:0]        req_addr,
    output logic [$clog2(TRACKER_SLOTS)-1:0]  req_slot,
    input  logic                              rsp_valid,
    input  logic [$clog2(TRACKER_SLOTS)-1:0]  rsp_slot,
    output logic                              retire_valid,
    output logic [$clog2(TRACE_ENTRIES)-1:0]  retire_index,
    output logic [DATA_ADDR_WIDTH-1:0]        retire_addr,
    output logic [$clog2(TRACKER_SLOTS):0]    occupancy,
    output logic                              tag_error
);

    localparam int SLOT_W = $clog2(TRACKER_SLOTS);
    localparam int OCC_W  = SLOT_W + 1;

    tracker_slot_t slots_q   [TRACKER_SLOTS];
    tracker_slot_t slots_nxt [TRACKER_SLOTS];

    logic                     ready_en_q;
    logic [TRACKER_SLOTS-1:0] free_vec, hit_vec, done_vec, make_vec_nxt;
    logic                     free_any, done_any, make_any;
    logic [SLOT_W-1:0]        free_idx, done_idx, make_idx;
    logic                     accept, issue, rsp_ok, rsp_bad;

    always_comb begin
        free_vec = '0;
        hit_vec  = '0;
        done_vec = '0;
        for (int i = 0; i < TRACKER_SLOTS; i++) begin
            free_vec[i] = !slots_q[i].occupied;
            hit_vec[i]  = slots_q[i].occupied && (slots_q[i].mem_addr == in_addr);
            done_vec[i] = slots_q[i].occupied && (slots_q[i].action == REQUEST_RETIRED);
        end
    end

    lowest_set_picker #(.N(TRACKER_SLOTS), .W(SLOT_W)) u_free_pick (
        .req_vec (free_vec),
        .idx     (free_idx),
        .any     (free_any)
    );

    lowest_set_picker #(.N(TRACKER_SLOTS), .W(SLOT_W)) u_done_pick (
        .req_vec (done_vec),
        .idx     (done_idx),
        .any     (done_any)
    );

    // ready_en_q keeps in_ready low through reset and the first cycle after release.
    assign in_ready = ready_en_q && free_any && !(|hit_vec);
    assign accept   = in_valid && in_ready;
    assign issue    = req_valid && req_ready;
    assign rsp_ok   = rsp_valid && slots_q[rsp_slot].occupied &&
                      (slots_q[rsp_slot].action == WAIT_FOR_PROCESSING);
    assign rsp_bad  = rsp_valid && !rsp_ok;

    always_comb begin
        for (int i = 0; i < TRACKER_SLOTS; i++) slots_nxt[i] = slots_q[i];
        if (accept) begin
            slots_nxt[free_idx].occupied    = 1'b1;
            slots_nxt[free_idx].mem_addr    = in_addr;
            slots_nxt[free_idx].action      = MAKE_REQUEST;
            slots_nxt[free_idx].trace_index = in_index;
        end
        if (issue)    slots_nxt[req_slot].action = WAIT_FOR_PROCESSING;
        if (rsp_ok)   slots_nxt[rsp_slot].action = REQUEST_RETIRED;
        if (done_any) slots_nxt[done_idx].occupied = 1'b0;
    end

    // Request selection looks at next state so a fresh entry is offered one cycle after acceptance.
    always_comb begin
        make_vec_nxt = '0;
        for (int i = 0; i < TRACKER_SLOTS; i++) begin
            make_vec_nxt[i] = slots_nxt[i].occupied && (slots_nxt[i].action == MAKE_REQUEST);
        end
    end

    lowest_set_picker #(.N(TRACKER_SLOTS), .W(SLOT_W)) u_make_pick (
        .req_vec (make_vec_nxt),
        .idx     (make_idx),
        .any     (make_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TRACKER_SLOTS; i++) slots_q[i] <= '0;
            ready_en_q   <= 1'b0;
            req_valid    <= 1'b0;
            req_addr     <= '0;
            req_slot     <= '0;
            retire_valid <= 1'b0;
            retire_index <= '0;
            retire_addr  <= '0;
            occupancy    <= '0;
            tag_error    <= 1'b0;
        end else begin
            for (int i = 0; i < TRACKER_SLOTS; i++) slots_q[i] <= slots_nxt[i];
            ready_en_q <= 1'b1;
            if (!(req_valid && !req_ready)) begin
                req_valid <= make_any;
                req_slot  <= make_idx;
                req_addr  <= slots_nxt[make_idx].mem_addr;
            end
            retire_valid <= done_any;
            retire_index <= done_any ? slots_q[done_idx].trace_index : '0;
            retire_addr  <= done_any ? slots_q[done_idx].mem_addr    : '0;
            occupancy    <= occupancy + OCC_W'(accept) - OCC_W'(done_any);
            tag_error    <= tag_error | rsp_bad;
        end
    end

endmodule
